// File: rtl/fifo_param.sv
// fifo_param
//   Parameterised synchronous FIFO built on a circular buffer.
//   It keeps an occupancy count, programmable almost-full and almost-empty
//   thresholds, and sticky overflow/underflow error flags.
//
// Ports
//   clk             in   sole clock, rising edge
//   reset_L         in   synchronous active-low reset (priority over all)
//   init            in   flush contents, clear errors, load thresholds
//   umbral_superior in   almost-full threshold (sampled while init=1)
//   umbral_inferior in   almost-empty threshold (sampled while init=1)
//   push, pop       in   write / read requests
//   data_in         in   write data
//   data_out        out  registered read data (1-cycle latency)
//   data_out_valid  out  high for one cycle after an accepted pop
//   full, empty, almost_full, almost_empty  out  status derived from fifo_count
//   fifo_count      out  occupancy 0..DEPTH
//   overflow_err, underflow_err  out  sticky error flags
module fifo_param #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned UMB_SUP_DEF = 6,
    parameter int unsigned UMB_INF_DEF = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   umbral_superior,
    input  logic [ADDR_WIDTH:0]   umbral_inferior,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         thr_sup;
    logic [CW-1:0]         thr_inf;

    logic pop_ok;
    logic push_ok;

    // Flags come straight from the registered count so they are valid in
    // the same cycle as fifo_count.
    always_comb begin
        full         = (fifo_count == CW'(DEPTH));
        empty        = (fifo_count == '0);
        almost_full  = (fifo_count >= thr_sup);
        almost_empty = (fifo_count <= thr_inf);
    end

    // A push into a full FIFO is still accepted when a pop frees a slot
    // on the same edge.
    always_comb begin
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (reset_L && !init && push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overflow_err   <= 1'b0;
            underflow_err  <= 1'b0;
            thr_sup        <= CW'(UMB_SUP_DEF);
            thr_inf        <= CW'(UMB_INF_DEF);
        end else if (init) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            data_out_valid <= 1'b0;
            overflow_err   <= 1'b0;
            underflow_err  <= 1'b0;
            thr_sup        <= umbral_superior;
            thr_inf        <= umbral_inferior;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end

            if (pop_ok) begin
                data_out       <= mem[rd_ptr];
                rd_ptr         <= rd_ptr + ADDR_WIDTH'(1);
                data_out_valid <= 1'b1;
            end else begin
                data_out_valid <= 1'b0;
            end

            case ({push_ok, pop_ok})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (push && !push_ok) begin
                overflow_err <= 1'b1;
            end
            if (pop && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule
